// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// wait-counter width and access-legality helpers.
package dmem_pkg;

    localparam int WAIT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
    endfunction

    // Half accesses (LH/LHU/SH) share funct3[1:0] == 01.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3 == F3_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage control (master) and the
// data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Lane select plus sign/zero extension of a 32-bit word for RISC-V loads.
// Low address bits are taken as aligned: halves use addr_lo[1], words ignore both.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data     = 32'h0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, extended loads and
// programmable wait states. Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses.
//
// state | meaning
// IDLE  | ready; request accepted when req_valid is high
// WAIT  | counting down wait states for the latched request
// RESP  | one-cycle response; RAM was accessed on the edge entering this state
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_e       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              ram_go;
    logic              op_we;
    logic [2:0]        op_f3;
    logic [IDX_W+1:0]  op_addr;
    logic [31:0]       op_wdata;
    logic              op_err;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word;
    logic              rsp_err_int;
    logic [31:0]       ext_data;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:IDX_W+2];

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == WAIT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            wait_cnt <= WAIT_W'(WAIT_STATES);
            we_q     <= bus.req_we;
            f3_q     <= bus.req_funct3;
            addr_q   <= bus.req_addr[IDX_W+1:0];
            wdata_q  <= bus.req_wdata;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    // With zero wait states the RAM edge is the accept edge, so the fields
    // that are being latched on that edge are taken straight from the bus.
    always_comb begin
        op_we    = (state == IDLE) ? bus.req_we     : we_q;
        op_f3    = (state == IDLE) ? bus.req_funct3 : f3_q;
        op_addr  = (state == IDLE) ? bus.req_addr[IDX_W+1:0] : addr_q;
        op_wdata = (state == IDLE) ? bus.req_wdata  : wdata_q;
    end

    assign ram_go = rst_n && (state_nxt == RESP) && (state != RESP);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign op_err      = f3_illegal(op_we, op_f3) || misaligned(op_f3, op_addr[1:0]);
    assign rsp_err_int = f3_illegal(we_q, f3_q) || misaligned(f3_q, addr_q[1:0]);
`else
    assign op_err      = f3_illegal(op_we, op_f3);
    assign rsp_err_int = f3_illegal(we_q, f3_q);
`endif

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = op_wdata;
        case (op_f3)
            F3_B: begin
                lane_en   = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wdata[7:0]}};
            end
            F3_H: begin
                lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wdata[15:0]}};
            end
            F3_W:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_go) begin
            if (op_we && !op_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i])
                        mem[op_addr[IDX_W+1:2]][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
            rd_word <= mem[op_addr[IDX_W+1:2]];
        end
    end

    dmem_load_ext u_load_ext (
        .word    (rd_word),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (ext_data)
    );

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) && rsp_err_int;
    assign bus.rsp_rdata = ((state == RESP) && !we_q && !rsp_err_int) ? ext_data : 32'h0;
    assign bus.stall     = bus.req_valid && (state != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states and one
// with three, sharing request fields but with separate valid and reset.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst0_n, rst3_n;
    logic        sel;
    logic        valid0, valid3;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    dmem_if if0 ();
    dmem_if if3 ();

    assign if0.req_valid  = valid0;
    assign if0.req_we     = we;
    assign if0.req_funct3 = f3;
    assign if0.req_addr   = addr;
    assign if0.req_wdata  = wdata;
    assign if3.req_valid  = valid3;
    assign if3.req_we     = we;
    assign if3.req_funct3 = f3;
    assign if3.req_addr   = addr;
    assign if3.req_wdata  = wdata;

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dmem0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (if0.slave)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dmem3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (if3.slave)
    );

    logic        rsp_v_s, rsp_err_s, stall_s, ready_s;
    logic [31:0] rsp_rdata_s;

    assign rsp_v_s     = sel ? if3.rsp_valid : if0.rsp_valid;
    assign rsp_err_s   = sel ? if3.rsp_err   : if0.rsp_err;
    assign rsp_rdata_s = sel ? if3.rsp_rdata : if0.rsp_rdata;
    assign stall_s     = sel ? if3.stall     : if0.stall;
    assign ready_s     = sel ? if3.req_ready : if0.req_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic set_valid(input logic v);
        if (sel) valid3 = v;
        else     valid0 = v;
    endtask

    // Holds the request until the response pulse, as the stalled pipeline would.
    task automatic access(input string tag, input logic w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic disturb);
        int cyc;
        int stalls;
        @(negedge clk);
        we = w; f3 = fn; addr = a; wdata = d;
        set_valid(1'b1);
        cyc = 0;
        stalls = 0;
        #1;
        while (!rsp_v_s && cyc < 32) begin
            stalls += int'(stall_s);
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 1) begin
                wdata = ~d;
                addr  = a + 32'd4;
            end
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        chk({tag, " rdata"}, rsp_rdata_s, exp_data);
        chk({tag, " err"}, 32'(rsp_err_s), 32'(exp_err));
        chk({tag, " stall in resp"}, 32'(stall_s), 32'd0);
        set_valid(1'b0);
        @(negedge clk);
        chk({tag, " pulse ends"}, 32'(rsp_v_s), 32'd0);
    endtask

    initial begin
        logic seen;
        sel = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
        we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        rst0_n = 1'b0; rst3_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1; rst3_n = 1'b1;
        #1;
        chk("rst ready0", 32'(if0.req_ready), 32'd1);
        chk("rst ready3", 32'(if3.req_ready), 32'd1);
        chk("rst rsp_valid0", 32'(if0.rsp_valid), 32'd0);
        chk("rst rsp_valid3", 32'(if3.rsp_valid), 32'd0);
        chk("rst rdata0", if0.rsp_rdata, 32'h0);
        chk("rst err0", 32'(if0.rsp_err), 32'd0);
        chk("rst stall0", 32'(if0.stall), 32'd0);

        sel = 1'b0;
        access("sw10",   1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1'b0);
        access("lw10",   1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0);
        access("sb13",   1'b1, F3_B,  32'h13, 32'h00000080, 32'h0,        1'b0, 1, 1'b0);
        access("lb13",   1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 1, 1'b0);
        access("lbu13",  1'b0, F3_BU, 32'h13, 32'h0,        32'h00000080, 1'b0, 1, 1'b0);
        access("lw10b",  1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 1, 1'b0);
        access("lb12",   1'b0, F3_B,  32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 1, 1'b0);
        access("sw20",   1'b1, F3_W,  32'h20, 32'h11223344, 32'h0,        1'b0, 1, 1'b0);
        access("sh22",   1'b1, F3_H,  32'h22, 32'h00008001, 32'h0,        1'b0, 1, 1'b0);
        access("lh22",   1'b0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, 1, 1'b0);
        access("lhu22",  1'b0, F3_HU, 32'h22, 32'h0,        32'h00008001, 1'b0, 1, 1'b0);
        access("lhu20",  1'b0, F3_HU, 32'h20, 32'h0,        32'h00003344, 1'b0, 1, 1'b0);
        access("st011",  1'b1, 3'b011, 32'h10, 32'h0,       32'h0,        1'b1, 1, 1'b0);
        access("lw10c",  1'b0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 1, 1'b0);
        access("ld110",  1'b0, 3'b110, 32'h10, 32'h0,       32'h0,        1'b1, 1, 1'b0);
        access("lwwrap", 1'b0, F3_W,  32'h1010, 32'h0,      32'h80ADBEEF, 1'b0, 1, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access("lw11",   1'b0, F3_W,  32'h11, 32'h0,        32'h0,        1'b1, 1, 1'b0);
        access("lh23",   1'b0, F3_H,  32'h23, 32'h0,        32'h0,        1'b1, 1, 1'b0);
`else
        access("lw11",   1'b0, F3_W,  32'h11, 32'h0,        32'h80ADBEEF, 1'b0, 1, 1'b0);
        access("lh23",   1'b0, F3_H,  32'h23, 32'h0,        32'hFFFF8001, 1'b0, 1, 1'b0);
`endif

        sel = 1'b1;
        access("ws3 sw40",  1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0, 4, 1'b0);
        access("ws3 sw44",  1'b1, F3_W, 32'h44, 32'h01020304, 32'h0,        1'b0, 4, 1'b1);
        access("ws3 lw44",  1'b0, F3_W, 32'h44, 32'h0,        32'h01020304, 1'b0, 4, 1'b0);
        access("ws3 lw40",  1'b0, F3_W, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, 4, 1'b0);

        @(negedge clk);
        we = 1'b1; f3 = F3_W; addr = 32'h40; wdata = 32'h12345678;
        valid3 = 1'b1;
        @(negedge clk);
        chk("rstmid in wait", 32'(if3.req_ready), 32'd0);
        valid3 = 1'b0;
        rst3_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid ready after release", 32'(if3.req_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            if (if3.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rstmid no rsp", 32'(seen), 32'd0);
        access("rstmid lw40", 1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
